alu_iter: RTL
=============

// Module: alu_iter
// PURPOSE
// - Parametrised multi-cycle successor to the single-cycle ALU. It executes the 11 base
//   alu_op_e operations with a fixed 1-cycle registered latency.
// - It also executes the RV32M/RV64M multiply/divide operations iteratively.
// - Sits in the EX stage of the multi-cycle/pipelined core.
// - Uses valid/ready on both sides so the control FSM or pipeline can stall on MUL/DIV.
// PARAMETERS
// - XLEN  32  operand/result width; legal values 32 or 64
// - SHW   $clog2(XLEN)  shift-amount width (derived; do not override)
// PORTS
// - clk_i         in   1     clock, all state on rising edge
// - rst_ni        in   1     async active-low reset
// - in_valid_i    in   1     operation request valid
// - in_ready_o    out  1     unit can accept a request this cycle
// - op_i          in   5     {m_sel, alu_op}: m_sel=0 -> op_i[3:0] is alu_op_e;
//                            m_sel=1 -> op_i[2:0] is the M-op
// - operand_a_i   in   XLEN  rs1 / pc operand
// - operand_b_i   in   XLEN  rs2 / immediate operand
// - out_valid_o   out  1     result valid
// - out_ready_i   in   1     consumer accepts result
// - result_o      out  XLEN  result, held stable while out_valid_o=1 and out_ready_i=0
// - illegal_o     out  1     qualifies result_o: op not supported
// BEHAVIOUR
// - Request accepted when in_valid_i && in_ready_o.
// - Result retired when out_valid_o && out_ready_i.
// - FSM states and transitions:
//   - IDLE -accept base/short-circuit op-> DONE
//   - IDLE -accept MUL/DIV op-> BUSY
//   - BUSY -counter==XLEN-1-> DONE
//   - DONE -retire, no accept-> IDLE
//   - DONE -retire + accept-> DONE or BUSY, per the new op (back-to-back)
// - in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). It is never high in BUSY.
// - Reset values: state=IDLE, out_valid_o=0, result_o=0, illegal_o=0, counter=0.
//   Internal accumulators are also cleared to 0.
// - Reset asserted mid-BUSY aborts the operation. No result is produced.
// - Base ops: result registered at accept. out_valid_o is high the cycle after accept.
//   - ADD/SUB: mod 2^XLEN, wrap silently.
//   - SLT/SLTU: result is {XLEN-1 zeros, bit}.
//   - SLL/SRL/SRA: use operand_b_i[SHW-1:0] only. SRA sign-fills.
//   - LUI: result = operand_b_i.
//   - Unused alu_op codes 4'hB..4'hF: result 0, illegal_o=1, 1-cycle latency.
// - M-ops (op_i[2:0]): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
//   - Multiply: radix-2 shift-add on magnitudes, one bit per cycle, XLEN cycles in BUSY.
//     - Sign fix-up is applied on the final BUSY cycle.
//     - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the
//       2*XLEN product.
//   - Divide: restoring, one quotient bit per cycle, XLEN cycles in BUSY.
//     - Signed ops divide magnitudes. Quotient sign = sign_a^sign_b; remainder sign = sign_a.
//   - MUL/DIV latency: out_valid_o rises exactly XLEN+1 cycles after the accept cycle.
//   - Divide by zero (b==0) short-circuits with 1-cycle latency:
//     - DIV/DIVU -> all ones
//     - REM/REMU -> operand_a
//   - Signed overflow (a==most negative, b==-1) short-circuits with 1-cycle latency:
//     - DIV -> a
//     - REM -> 0
//   - Operands are captured at accept. Input changes during BUSY have no effect.
// - in_valid_i while not ready: the request is not accepted and must be held by the source.
// CONFIGURATION
// - Macro ALU_ITER_MEXT_EN.
// - Defined: M-ops are implemented as described above.
// - Undefined: no multiply/divide datapath is generated. Every op with op_i[4]=1 completes
//   with 1-cycle latency, result_o=0 and illegal_o=1. BUSY is unreachable.
// TESTING
// - Tests use XLEN=32.
// - Reset/base ops:
//   - rst_ni=0 -> out_valid_o=0, result_o=0, in_ready_o=1.
//   - ADD 0xFFFFFFFF+1 -> 0x0 one cycle later.
//   - SRA 0x80000000>>>0x24 -> 0xF8000000 (shamt=4).
// - Multiply:
//   - MULH 0x80000000*0x80000000 -> 0x40000000; out_valid_o at accept+33; in_ready_o=0 in BUSY.
//   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
// - Divide corner cases:
//   - DIV 7/0 -> 0xFFFFFFFF at accept+1.
//   - REMU 7/0 -> 0x7.
//   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//   - REM -7/2 -> 0xFFFFFFFF.
// - Backpressure/back-to-back:
//   - Hold out_ready_i=0 for 5 cycles after DIVU 100/7 -> result_o stays 0xE, stable.
//   - Then assert out_ready_i with a new ADD valid -> it is accepted in the same cycle.
// - Reset mid-operation / config:
//   - Drop rst_ni at BUSY cycle 10 -> IDLE; no out_valid_o ever for that op.
//   - Without ALU_ITER_MEXT_EN: MUL -> result 0, illegal_o=1, at accept+1.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle EX-stage ALU with valid/ready handshakes on both sides.
//
// Base ops (op_i[4]=0, op_i[3:0] = alu_op) complete with 1-cycle registered latency:
//   0 ADD  1 SUB  2 SLL  3 SLT  4 SLTU  5 XOR  6 SRL  7 SRA  8 OR  9 AND  10 LUI
//   11..15 unused: result 0, illegal_o=1.
// M-ops (op_i[4]=1, op_i[2:0]):
//   0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   Multiply is radix-2 shift-add and divide is restoring, both one bit per cycle over
//   XLEN cycles, giving out_valid_o XLEN+1 cycles after accept. Divide by zero and signed
//   overflow short-circuit with 1-cycle latency.
//
// Configuration macro ALU_ITER_MEXT_EN: when undefined, no mul/div datapath is built and
// every M-op completes in one cycle with result 0 and illegal_o=1.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   in_valid_i / in_ready_o   request handshake; op_i, operand_a_i, operand_b_i captured
//   out_valid_o / out_ready_i result handshake; result_o, illegal_o held until retired
module alu_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            accept;

  assign in_ready_o  = (state_q == StIdle) | ((state_q == StDone) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;
  assign illegal_o   = illegal_q;

  // ---------------------------------------------------------------------------
  // Base ALU
  // ---------------------------------------------------------------------------
  logic [3:0]             alu_op;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0]        base_res;
  logic                   base_ill;

  assign alu_op  = op_i[3:0];
  assign shamt   = operand_b_i[SHW-1:0];
  assign sra_res = $signed(operand_a_i) >>> shamt;

  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    case (alu_op)
      4'h0: base_res = operand_a_i + operand_b_i;
      4'h1: base_res = operand_a_i - operand_b_i;
      4'h2: base_res = operand_a_i << shamt;
      4'h3: base_res = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      4'h4: base_res = {{(XLEN-1){1'b0}}, operand_a_i < operand_b_i};
      4'h5: base_res = operand_a_i ^ operand_b_i;
      4'h6: base_res = operand_a_i >> shamt;
      4'h7: base_res = sra_res;
      4'h8: base_res = operand_a_i | operand_b_i;
      4'h9: base_res = operand_a_i & operand_b_i;
      4'hA: base_res = operand_b_i;
      default: base_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply / divide datapath
  // ---------------------------------------------------------------------------
  logic            start_iter;
  logic [XLEN-1:0] short_res;
  logic            short_ill;

`ifdef ALU_ITER_MEXT_EN
  logic [2:0]      mop;
  logic            a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  // hi_q: product high half / partial remainder
  // lo_q: multiplier being consumed / dividend shifting out, quotient shifting in
  // dvs_q: multiplicand / divisor magnitude
  logic [XLEN-1:0] hi_q, lo_q, dvs_q;
  logic [2:0]      mop_q;
  logic            sa_q, sb_q;
  logic [SHW-1:0]  cnt_q;

  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   hi_n, lo_n, quo_s, rem_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   final_res;
  logic              last_step;

  assign mop = op_i[2:0];

  always_comb begin
    a_signed = (mop == 3'd0) | (mop == 3'd1) | (mop == 3'd2) | (mop == 3'd4) | (mop == 3'd6);
    b_signed = (mop == 3'd0) | (mop == 3'd1) | (mop == 3'd4) | (mop == 3'd6);
    sa       = a_signed & operand_a_i[XLEN-1];
    sb       = b_signed & operand_b_i[XLEN-1];
    mag_a    = sa ? -operand_a_i : operand_a_i;
    mag_b    = sb ? -operand_b_i : operand_b_i;
    div_zero = mop[2] & (operand_b_i == '0);
    // Only DIV/REM (mop[0]=0) are signed and can overflow.
    div_ovf  = mop[2] & ~mop[0] & (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&operand_b_i);
  end

  always_comb begin
    start_iter = 1'b0;
    short_res  = base_res;
    short_ill  = base_ill;
    if (op_i[4]) begin
      short_ill = 1'b0;
      short_res = '0;
      if (div_zero) begin
        short_res = mop[1] ? operand_a_i : '1;
      end else if (div_ovf) begin
        short_res = mop[1] ? '0 : operand_a_i;
      end else begin
        start_iter = 1'b1;
      end
    end
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, dvs_q};
    // Partial remainder is always below the divisor, so the borrow bit is exact.
    div_ge    = ~div_diff[XLEN];
    if (mop_q[2]) begin
      hi_n = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_s = (sa_q ^ sb_q) ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo_s  = (sa_q ^ sb_q) ? -lo_n : lo_n;
    rem_s  = sa_q ? -hi_n : hi_n;
    if (mop_q[2]) begin
      final_res = mop_q[1] ? rem_s : quo_s;
    end else if (mop_q == 3'd0) begin
      final_res = prod_s[XLEN-1:0];
    end else begin
      final_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  // XLEN is a power of two, so the final count is all ones.
  assign last_step = &cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dvs_q <= '0;
      mop_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept && start_iter) begin
      hi_q  <= '0;
      lo_q  <= mop[2] ? mag_a : mag_b;
      dvs_q <= mop[2] ? mag_b : mag_a;
      mop_q <= mop;
      sa_q  <= sa;
      sb_q  <= sb;
      cnt_q <= '0;
    end else if (state_q == StBusy) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + SHW'(1);
    end
  end
`else
  always_comb begin
    start_iter = 1'b0;
    short_res  = base_res;
    short_ill  = base_ill;
    if (op_i[4]) begin
      short_res = '0;
      short_ill = 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: state_d = StIdle;
      StBusy: begin
`ifdef ALU_ITER_MEXT_EN
        if (last_step) begin
          state_d   = StDone;
          result_d  = final_res;
          illegal_d = 1'b0;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Accept (including back-to-back from DONE) overrides the retire path.
    if (accept) begin
      if (start_iter) begin
        state_d = StBusy;
      end else begin
        state_d   = StDone;
        result_d  = short_res;
        illegal_d = short_ill;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
